keypad_scan_decoder: RTL and testbench

//  Scans a 4x4 active-low matrix keypad, debounces, and decodes one press into a 4-bit hex
//  key code with a valid/ready handshake. Input-side companion of the 7-seg digit display

---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/keypad_scan_decoder_scan_tick_gen.sv | 29 ++
 rtl/keypad_scan_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_keypad_scan_decoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
//   kp_state_e   : scan / debounce FSM states
//   KEYMAP       : key code per {row, col}, row 3 holds '*' (E) and '#' (F)
//   lowest_col   : index of the lowest active-low column in a sensed pattern
//   row_onehot0  : active-low row drive for a row index
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2,
    REL_DB   = 2'd3
  } kp_state_e;

  // Packed so that KEYMAP[{row,col}] selects the code; listed from index 15 down to 0.
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hF, 4'h0, 4'hE,   // row 3
    4'hC, 4'h9, 4'h8, 4'h7,   // row 2
    4'hB, 4'h6, 4'h5, 4'h4,   // row 1
    4'hA, 4'h3, 4'h2, 4'h1    // row 0
  };

  // Lowest-index column pulled low wins; an all-high pattern is never looked up.
  function automatic logic [1:0] lowest_col(input logic [3:0] col_s);
    if (!col_s[0]) begin
      return 2'd0;
    end else if (!col_s[1]) begin
      return 2'd1;
    end else if (!col_s[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  function automatic logic [3:0] row_onehot0(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scan_decoder_scan_tick_gen.sv
// Free-running scan divider producing a one-cycle tick each time it wraps.
//   clk    : system clock
//   rst_n  : asynchronous reset, active-low
//   tick_o : registered pulse, high for one cycle after the divider wraps to 0
module scan_tick_gen #(
  parameter int SCAN_DIV_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  logic [SCAN_DIV_W-1:0] div_q;
  logic                  tick_q;

  // Divider count and registered wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_q + SCAN_DIV_W'(1);
      tick_q <= &div_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/keypad_scan_decoder.sv
// 4x4 active-low keypad scanner with debounce and a valid/ready key output.
//   clk       : system clock
//   reset     : asynchronous reset, active-low
//   row       : active-low row drive, one row low at a time
//   col       : active-low column sense, asynchronous to clk
//   key_code  : decoded hex key, stable while key_valid
//   key_valid : key_code holds an unconsumed key
//   key_ready : consumer takes the key when key_valid & key_ready
//   key_held  : a debounced key is currently down
//   overrun   : sticky, a key was debounced while the previous one was unconsumed
//   clr_ovr   : synchronous clear of overrun, wins over a same-cycle set
module keypad_scan_decoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W     = 16,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun,
  input  logic       clr_ovr
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             tick_s;
  logic [3:0]       col_meta_q;
  logic [3:0]       col_s_q;
  kp_state_e        state_q;
  logic [1:0]       row_idx_q;
  logic [3:0]       row_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [3:0]       lat_col_q;
  logic [3:0]       pend_code_q;
  logic             emit_q;
  logic             key_held_q;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q,  key_code_d;
  logic             overrun_q,   overrun_d;
  logic             accept_s;

  scan_tick_gen #(.SCAN_DIV_W(SCAN_DIV_W)) u_tick (
    .clk    (clk),
    .rst_n  (reset),
    .tick_o (tick_s)
  );

  // Two-flop synchroniser for the asynchronous column sense lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
    end else begin
      col_meta_q <= col;
      col_s_q    <= col_meta_q;
    end
  end

  // Saturating increment so the counter can never wrap back into a false match.
  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // Scan / debounce FSM; only moves on ticks, emit_q pulses for one cycle after a press completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      row_idx_q   <= 2'd0;
      row_q       <= 4'b1110;
      cnt_q       <= '0;
      lat_col_q   <= 4'hF;
      pend_code_q <= 4'h0;
      emit_q      <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      emit_q <= 1'b0;
      if (tick_s) begin
        case (state_q)
          SCAN: begin
            if (col_s_q == 4'hF) begin
              row_idx_q <= row_idx_q + 2'd1;
              row_q     <= row_onehot0(row_idx_q + 2'd1);
            end else begin
              lat_col_q   <= col_s_q;
              pend_code_q <= KEYMAP[{row_idx_q, lowest_col(col_s_q)}];
              cnt_q       <= CNT_ONE;
              if (CNT_ONE == CNT_MAX) begin
                state_q    <= PRESSED;
                emit_q     <= 1'b1;
                key_held_q <= 1'b1;
              end else begin
                state_q <= PRESS_DB;
              end
            end
          end
          PRESS_DB: begin
            if (col_s_q == lat_col_q) begin
              cnt_q <= cnt_inc_s;
              if (cnt_inc_s == CNT_MAX) begin
                state_q    <= PRESSED;
                emit_q     <= 1'b1;
                key_held_q <= 1'b1;
              end
            end else begin
              cnt_q     <= '0;
              state_q   <= SCAN;
              row_idx_q <= row_idx_q + 2'd1;
              row_q     <= row_onehot0(row_idx_q + 2'd1);
            end
          end
          PRESSED: begin
            if (col_s_q == 4'hF) begin
              if (CNT_ONE == CNT_MAX) begin
                cnt_q      <= '0;
                state_q    <= SCAN;
                key_held_q <= 1'b0;
                row_idx_q  <= row_idx_q + 2'd1;
                row_q      <= row_onehot0(row_idx_q + 2'd1);
              end else begin
                cnt_q   <= CNT_ONE;
                state_q <= REL_DB;
              end
            end
          end
          REL_DB: begin
            if (col_s_q == 4'hF) begin
              cnt_q <= cnt_inc_s;
              if (cnt_inc_s == CNT_MAX) begin
                cnt_q      <= '0;
                state_q    <= SCAN;
                key_held_q <= 1'b0;
                row_idx_q  <= row_idx_q + 2'd1;
                row_q      <= row_onehot0(row_idx_q + 2'd1);
              end
            end else begin
              // Release bounce: return to the held state without a second emit.
              cnt_q   <= '0;
              state_q <= PRESSED;
            end
          end
          default: begin
            cnt_q      <= '0;
            state_q    <= SCAN;
            key_held_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign accept_s = key_valid_q & key_ready;

  // Output handshake: load on emit if the slot is free or being drained, otherwise flag overrun.
  always_comb begin
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    if (emit_q) begin
      if (!key_valid_q || accept_s) begin
        key_code_d  = pend_code_q;
        key_valid_d = 1'b1;
      end else begin
        key_code_d  = key_code_q;
      end
    end else if (accept_s) begin
      key_valid_d = 1'b0;
    end else begin
      key_valid_d = key_valid_q;
    end
    if (clr_ovr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q | (emit_q & key_valid_q & ~accept_s);
    end
  end

  // Handshake and overrun registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      overrun_q   <= 1'b0;
    end else begin
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      overrun_q   <= overrun_d;
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Directed bench for keypad_scan_decoder with a physical keypad model:
// a pressed key at (r,c) pulls col[c] low whenever row[r] is driven low.
module tb_keypad_scan_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready = 1'b0;
  logic        key_held;
  logic        overrun;
  logic        clr_ovr = 1'b0;
  logic [15:0] keys_m = 16'h0000;

  int n_vec  = 0;
  int n_miss = 0;
  int rises  = 0;
  logic prev_valid = 1'b0;

  keypad_scan_decoder #(.SCAN_DIV_W(2), .DEBOUNCE_TICKS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  always #5 clk = ~clk;

  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys_m[r*4+c] && !row[r]) col[c] = 1'b0;
      end
    end
  end

  // Count 0->1 transitions of key_valid (fresh emits into an empty slot).
  always @(negedge clk) begin
    if (key_valid && !prev_valid) rises++;
    prev_valid = key_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget && key_valid !== 1'b1; i++) step(1);
    chk(tag, key_valid, 1'b1);
  endtask

  task automatic wait_held(input string tag, input logic val, input int budget);
    for (int i = 0; i < budget && key_held !== val; i++) step(1);
    chk(tag, key_held, val);
  endtask

  task automatic accept_key();
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_row"},   row,       4'b1110);
    chk({tag, "_valid"}, key_valid, 1'b0);
    chk({tag, "_code"},  key_code,  4'h0);
    chk({tag, "_held"},  key_held,  1'b0);
    chk({tag, "_ovr"},   overrun,   1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_rows [5];
    logic [3:0] prev_row;
    int         cyc;

    exp_rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};

    // 1: reset values and idle row scan
    #2 reset = 1'b0;
    #1 check_reset_vals("t1_reset");
    step(3);
    release_reset();
    prev_row = row;
    for (int k = 0; k < 5; k++) begin
      cyc = 0;
      while (row == prev_row && cyc < 20) begin
        step(1);
        cyc++;
      end
      chk("t1_row", row, exp_rows[k]);
      if (k > 0) chk("t1_interval", cyc, 4);
      prev_row = row;
    end
    chk("t1_idle_valid", key_valid, 1'b0);

    // 2: clean press of '6' (r1c2), accept, long hold without repeat
    rises = 0;
    keys_m[6] = 1'b1;
    step(8);
    chk("t2_no_early_valid", key_valid, 1'b0);
    wait_valid("t2_valid", 100);
    chk("t2_code", key_code, 4'h6);
    chk("t2_held", key_held, 1'b1);
    accept_key();
    chk("t2_accepted", key_valid, 1'b0);
    step(200);
    chk("t2_no_repeat", key_valid, 1'b0);
    chk("t2_still_held", key_held, 1'b1);
    chk("t2_rises", rises, 1);
    keys_m = 16'h0000;
    wait_held("t2_released", 1'b0, 100);

    // 3: bouncing press of '0' (r3c1), then bouncing release
    rises = 0;
    for (int i = 0; i < 5; i++) begin
      keys_m[13] = (i % 2 == 0);
      step(4);
    end
    keys_m[13] = 1'b1;
    wait_valid("t3_valid", 120);
    step(40);
    chk("t3_code", key_code, 4'h0);
    chk("t3_single_emit", rises, 1);
    chk("t3_no_ovr", overrun, 1'b0);
    accept_key();
    keys_m[13] = 1'b0;
    step(4);
    keys_m[13] = 1'b1;
    step(4);
    keys_m[13] = 1'b0;
    wait_held("t3_released", 1'b0, 100);
    step(40);
    chk("t3_no_reemit", key_valid, 1'b0);
    chk("t3_rises_after_rel", rises, 1);

    // 4: overrun - '5' unconsumed, then '9'
    keys_m[5] = 1'b1;
    wait_valid("t4_valid5", 120);
    keys_m = 16'h0000;
    wait_held("t4_rel5", 1'b0, 100);
    keys_m[10] = 1'b1;
    wait_held("t4_held9", 1'b1, 120);
    step(3);
    chk("t4_code_kept", key_code, 4'h5);
    chk("t4_valid_kept", key_valid, 1'b1);
    chk("t4_overrun", overrun, 1'b1);
    keys_m = 16'h0000;
    wait_held("t4_rel9", 1'b0, 100);
    chk("t4_ovr_sticky", overrun, 1'b1);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    chk("t4_ovr_clr", overrun, 1'b0);
    accept_key();
    chk("t4_drained", key_valid, 1'b0);

    // 5: two columns on row 2 -> '7'; accept during emit of 'D'
    keys_m[8] = 1'b1;
    keys_m[9] = 1'b1;
    wait_valid("t5_valid7", 120);
    chk("t5_code7", key_code, 4'h7);
    keys_m = 16'h0000;
    wait_held("t5_rel7", 1'b0, 100);
    keys_m[15] = 1'b1;
    wait_held("t5_heldD", 1'b1, 120);
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    chk("t5_codeD", key_code, 4'hD);
    chk("t5_validD", key_valid, 1'b1);
    chk("t5_no_ovr", overrun, 1'b0);
    keys_m = 16'h0000;
    wait_held("t5_relD", 1'b0, 100);
    accept_key();
    chk("t5_drained", key_valid, 1'b0);

    // 6a: reset while key_valid=1, key kept down
    keys_m[2] = 1'b1;
    wait_valid("t6_valid3", 120);
    reset = 1'b0;
    #1 check_reset_vals("t6a_reset");
    step(2);
    rises = 0;
    release_reset();
    step(6);
    chk("t6a_no_early", key_valid, 1'b0);
    wait_valid("t6a_valid", 60);
    chk("t6a_code", key_code, 4'h3);
    step(40);
    chk("t6a_single", rises, 1);
    chk("t6a_no_ovr", overrun, 1'b0);
    keys_m = 16'h0000;
    wait_held("t6a_rel", 1'b0, 100);
    accept_key();

    // 6b: reset in the middle of press debounce of '1'
    for (int i = 0; i < 20 && row == 4'b1110; i++) step(1);
    for (int i = 0; i < 20 && row != 4'b1110; i++) step(1);
    chk("t6b_row0", row, 4'b1110);
    keys_m[0] = 1'b1;
    step(6);
    reset = 1'b0;
    #1 check_reset_vals("t6b_reset");
    step(2);
    rises = 0;
    release_reset();
    step(6);
    chk("t6b_no_early", key_valid, 1'b0);
    wait_valid("t6b_valid", 60);
    chk("t6b_code", key_code, 4'h1);
    step(40);
    chk("t6b_single", rises, 1);
    keys_m = 16'h0000;
    wait_held("t6b_rel", 1'b0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
